// File: rtl/gbt_rx_pattern_checker_pkg.sv
// Shared definitions for the GBT RX pattern checker.
//   gbt_rx_state_e      : checker FSM state, encoded as the state_ob code
//   DEFAULT_LOCK_COUNT  : consecutive good words needed to declare lock
//   DEFAULT_UNLOCK_ERRS : consecutive bad words that drop lock
package gbt_rx_pattern_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_LOCKING = 2'd2,
    ST_LOCKED  = 2'd3
  } gbt_rx_state_e;

  localparam int DEFAULT_LOCK_COUNT  = 16;
  localparam int DEFAULT_UNLOCK_ERRS = 4;

endpackage

// File: rtl/gbt_rx_pattern_checker_sat_counter.sv
// Saturating up-counter used for the mismatch count.
// Ports:
//   clk_ik : clock
//   rst_ir : asynchronous active-high reset, zeroes the count
//   inc_i  : increment request, ignored once the count is all-ones
//   clr_i  : synchronous clear, wins over inc_i
//   cnt_ob : current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_ik,
  input  logic             rst_ir,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_ob
);

  always_ff @(posedge clk_ik or posedge rst_ir) begin
    if (rst_ir) begin
      cnt_ob <= '0;
    end else if (clr_i) begin
      cnt_ob <= '0;
    end else if (inc_i && (cnt_ob != '1)) begin
      cnt_ob <= cnt_ob + 1'b1;
    end
  end

endmodule

// File: rtl/gbt_rx_pattern_checker.sv
// Checks the incrementing-counter test pattern on the received-data output
// of the GBT bank, in the RX frame clock domain. A word only counts on
// cycles where rx_valid_i is high; every word is expected to be the
// previous word plus one (mod 2^DATA_W).
// Ports:
//   clk_ik       : RX frame clock
//   rst_ir       : asynchronous active-high reset
//   rx_ready_i   : GBT RX ready, low means link down (forces IDLE)
//   rx_valid_i   : frame-valid strobe
//   rx_data_ib   : received word
//   clear_i      : synchronous clear of counters and lost-lock flag
//   locked_o     : high while in LOCKED
//   state_ob     : FSM state code (IDLE=0 SEARCH=1 LOCKING=2 LOCKED=3)
//   err_o        : one-cycle pulse per mismatching word while locked
//   err_cnt_ob   : saturating mismatch count while locked
//   frame_cnt_ob : matching words seen while locked, wraps
//   lost_lock_o  : sticky, set whenever LOCKED is left
module gbt_rx_pattern_checker
  import gbt_rx_pattern_checker_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int LOCK_COUNT  = DEFAULT_LOCK_COUNT,
  parameter int UNLOCK_ERRS = DEFAULT_UNLOCK_ERRS,
  parameter int ERRCNT_W    = 16
) (
  input  logic                clk_ik,
  input  logic                rst_ir,
  input  logic                rx_ready_i,
  input  logic                rx_valid_i,
  input  logic [DATA_W-1:0]   rx_data_ib,
  input  logic                clear_i,
  output logic                locked_o,
  output logic [1:0]          state_ob,
  output logic                err_o,
  output logic [ERRCNT_W-1:0] err_cnt_ob,
  output logic [31:0]         frame_cnt_ob,
  output logic                lost_lock_o
);

  // Run counters only need to reach LOCK_COUNT-1 / UNLOCK_ERRS-1: the word
  // that would complete the run triggers the transition instead.
  localparam int GOOD_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int BAD_W  = (UNLOCK_ERRS > 1) ? $clog2(UNLOCK_ERRS) : 1;
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_ERRS - 1);

  gbt_rx_state_e     state_q, state_nxt;
  logic [DATA_W-1:0] expected_p1, expected_nxt;
  logic [GOOD_W-1:0] good_q, good_nxt;
  logic [BAD_W-1:0]  bad_q, bad_nxt;
  logic              err_q, err_nxt;
  logic [31:0]       frame_q;
  logic              lost_q;
  logic              frame_inc;
  logic              lost_set;
  logic              match;
  logic [DATA_W-1:0] data_plus1;

  assign data_plus1 = rx_data_ib + 1'b1;
  assign match      = (rx_data_ib == expected_p1);

  always_comb begin
    state_nxt    = state_q;
    expected_nxt = expected_p1;
    good_nxt     = good_q;
    bad_nxt      = bad_q;
    err_nxt      = 1'b0;
    frame_inc    = 1'b0;
    lost_set     = 1'b0;
    if (!rx_ready_i) begin
      state_nxt = ST_IDLE;
      lost_set  = (state_q == ST_LOCKED);
    end else begin
      case (state_q)
        ST_IDLE: state_nxt = ST_SEARCH;
        ST_SEARCH: begin
          if (rx_valid_i) begin
            expected_nxt = data_plus1;
            good_nxt     = '0;
            state_nxt    = ST_LOCKING;
          end
        end
        ST_LOCKING: begin
          if (rx_valid_i) begin
            // On a mismatch the pattern restarts from the received word.
            expected_nxt = data_plus1;
            if (!match) begin
              good_nxt = '0;
            end else if (good_q == GOOD_LAST) begin
              good_nxt  = '0;
              bad_nxt   = '0;
              state_nxt = ST_LOCKED;
            end else begin
              good_nxt = good_q + 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (rx_valid_i) begin
            expected_nxt = data_plus1;
            if (match) begin
              bad_nxt   = '0;
              frame_inc = 1'b1;
            end else begin
              err_nxt = 1'b1;
              if (bad_q == BAD_LAST) begin
                bad_nxt   = '0;
                lost_set  = 1'b1;
                state_nxt = ST_SEARCH;
              end else begin
                bad_nxt = bad_q + 1'b1;
              end
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Stage boundary: all checker state and outputs registered here.
  always_ff @(posedge clk_ik or posedge rst_ir) begin
    if (rst_ir) begin
      state_q     <= ST_IDLE;
      expected_p1 <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      err_q       <= 1'b0;
      frame_q     <= '0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      expected_p1 <= expected_nxt;
      good_q      <= good_nxt;
      bad_q       <= bad_nxt;
      err_q       <= err_nxt;
      if (clear_i) begin
        frame_q <= '0;
        lost_q  <= 1'b0;
      end else begin
        if (frame_inc) frame_q <= frame_q + 32'd1;
        if (lost_set)  lost_q  <= 1'b1;
      end
    end
  end

  sat_counter #(
    .WIDTH(ERRCNT_W)
  ) u_err_cnt (
    .clk_ik(clk_ik),
    .rst_ir(rst_ir),
    .inc_i (err_nxt),
    .clr_i (clear_i),
    .cnt_ob(err_cnt_ob)
  );

  assign state_ob     = state_q;
  assign locked_o     = (state_q == ST_LOCKED);
  assign err_o        = err_q;
  assign frame_cnt_ob = frame_q;
  assign lost_lock_o  = lost_q;

endmodule

// File: tb/tb_gbt_rx_pattern_checker.sv
// Bench for gbt_rx_pattern_checker: table-driven lock-up sequence, hand
// written corner sequences and a randomized run against a reference model.
// The error counter is built 8 bits wide so saturation is reachable quickly.
module tb_gbt_rx_pattern_checker;

  localparam int DATA_W   = 32;
  localparam int LOCKN    = 16;
  localparam int UNLOCKN  = 4;
  localparam int ERRCNT_W = 8;
  localparam int ERRMAX   = (1 << ERRCNT_W) - 1;

  logic                clk_ik = 1'b0;
  logic                rst_ir;
  logic                rx_ready_i;
  logic                rx_valid_i;
  logic [DATA_W-1:0]   rx_data_ib;
  logic                clear_i;
  logic                locked_o;
  logic [1:0]          state_ob;
  logic                err_o;
  logic [ERRCNT_W-1:0] err_cnt_ob;
  logic [31:0]         frame_cnt_ob;
  logic                lost_lock_o;

  gbt_rx_pattern_checker #(
    .DATA_W(DATA_W), .LOCK_COUNT(LOCKN), .UNLOCK_ERRS(UNLOCKN), .ERRCNT_W(ERRCNT_W)
  ) dut (
    .clk_ik(clk_ik), .rst_ir(rst_ir), .rx_ready_i(rx_ready_i), .rx_valid_i(rx_valid_i),
    .rx_data_ib(rx_data_ib), .clear_i(clear_i), .locked_o(locked_o), .state_ob(state_ob),
    .err_o(err_o), .err_cnt_ob(err_cnt_ob), .frame_cnt_ob(frame_cnt_ob), .lost_lock_o(lost_lock_o)
  );

  always #5 clk_ik = ~clk_ik;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: tracks the last accepted word and run lengths directly.
  int          m_state;   // 0 idle, 1 search, 2 locking, 3 locked
  logic [31:0] m_prev;
  int          m_good;
  int          m_bad;
  bit          m_err;
  int          m_errcnt;
  logic [31:0] m_frame;
  bit          m_lost;

  task automatic model_reset();
    m_state = 0; m_prev = '0; m_good = 0; m_bad = 0;
    m_err = 0; m_errcnt = 0; m_frame = '0; m_lost = 0;
  endtask

  function automatic logic [31:0] model_exp();
    return m_prev + 32'd1;
  endfunction

  task automatic model_step(input bit rdy, input bit vld, input logic [31:0] d, input bit clr);
    int ns;
    bit e;
    bit good;
    ns = m_state;
    e  = 0;
    good = (d == model_exp());
    if (!rdy) begin
      if (m_state == 3) m_lost = 1;
      ns = 0;
    end else if (m_state == 0) begin
      ns = 1;
    end else if (vld) begin
      if (m_state == 1) begin
        m_good = 0;
        ns = 2;
      end else if (m_state == 2) begin
        m_good = good ? m_good + 1 : 0;
        if (m_good == LOCKN) begin
          ns = 3; m_good = 0; m_bad = 0;
        end
      end else begin
        if (good) begin
          m_bad = 0;
          m_frame = m_frame + 32'd1;
        end else begin
          e = 1;
          m_bad++;
          if (m_errcnt < ERRMAX) m_errcnt++;
          if (m_bad == UNLOCKN) begin
            ns = 1; m_lost = 1; m_bad = 0;
          end
        end
      end
      m_prev = d;
    end
    if (clr) begin
      m_errcnt = 0; m_frame = '0; m_lost = 0;
    end
    m_err = e;
    m_state = ns;
  endtask

  task automatic check_model();
    chk("model_state", 64'(state_ob), 64'(m_state));
    chk("model_locked", 64'(locked_o), 64'(m_state == 3));
    chk("model_err", 64'(err_o), 64'(m_err));
    chk("model_errcnt", 64'(err_cnt_ob), 64'(m_errcnt));
    chk("model_frame", 64'(frame_cnt_ob), 64'(m_frame));
    chk("model_lost", 64'(lost_lock_o), 64'(m_lost));
  endtask

  task automatic drive(input bit rdy, input bit vld, input logic [31:0] d, input bit clr);
    rx_ready_i = rdy; rx_valid_i = vld; rx_data_ib = d; clear_i = clr;
    model_step(rdy, vld, d, clr);
    @(posedge clk_ik); #1;
    check_model();
  endtask

  task automatic check_all_reset(input string tag);
    chk({tag, "_state"}, 64'(state_ob), 64'd0);
    chk({tag, "_locked"}, 64'(locked_o), 64'd0);
    chk({tag, "_err"}, 64'(err_o), 64'd0);
    chk({tag, "_errcnt"}, 64'(err_cnt_ob), 64'd0);
    chk({tag, "_frame"}, 64'(frame_cnt_ob), 64'd0);
    chk({tag, "_lost"}, 64'(lost_lock_o), 64'd0);
  endtask

  typedef struct {
    logic        rdy;
    logic        vld;
    logic [31:0] data;
    logic [1:0]  st;
    logic        lk;
    logic [31:0] frame;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] d;
    logic [31:0] base;
    int nerr;
    int err_pct;
    vec_t v;

    // Table: IDLE->SEARCH, then counter 0..19 with a bubble after word 5.
    tbl.push_back('{1'b1, 1'b0, 32'h0, 2'd1, 1'b0, 32'd0});
    for (int i = 0; i < 20; i++) begin
      tbl.push_back('{1'b1, 1'b1, 32'(i), (i < 16) ? 2'd2 : 2'd3, (i >= 16),
                      (i >= 17) ? 32'(i - 16) : 32'd0});
      if (i == 5) tbl.push_back('{1'b1, 1'b0, 32'hDEAD, 2'd2, 1'b0, 32'd0});
    end

    rst_ir = 1'b1; rx_ready_i = 0; rx_valid_i = 0; rx_data_ib = '0; clear_i = 0;
    model_reset();
    #1;
    check_all_reset("por");
    @(posedge clk_ik); @(posedge clk_ik); #1;
    rst_ir = 1'b0;

    foreach (tbl[k]) begin
      v = tbl[k];
      drive(v.rdy, v.vld, v.data, 1'b0);
      chk("tbl_state", 64'(state_ob), 64'(v.st));
      chk("tbl_locked", 64'(locked_o), 64'(v.lk));
      chk("tbl_frame", 64'(frame_cnt_ob), 64'(v.frame));
    end
    chk("lock_errcnt", 64'(err_cnt_ob), 64'd0);

    // Single bad word while locked, pattern resumes from it.
    for (int i = 20; i < 32'h100; i++) drive(1, 1, 32'(i), 0);
    drive(1, 1, 32'h1234, 0);
    chk("inj_err", 64'(err_o), 64'd1);
    chk("inj_errcnt", 64'(err_cnt_ob), 64'd1);
    chk("inj_locked", 64'(locked_o), 64'd1);
    drive(1, 1, 32'h1235, 0);
    chk("inj_next_err", 64'(err_o), 64'd0);
    chk("inj_next_errcnt", 64'(err_cnt_ob), 64'd1);
    chk("inj_next_locked", 64'(locked_o), 64'd1);

    // Counter wrap through all-ones is not an error.
    drive(1, 1, 32'hFFFF_FFFD, 0);
    chk("wrap_setup_errcnt", 64'(err_cnt_ob), 64'd2);
    base = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, base, 0);
      chk("wrap_err", 64'(err_o), 64'd0);
      base = base + 32'd1;
    end
    chk("wrap_errcnt", 64'(err_cnt_ob), 64'd2);
    chk("wrap_locked", 64'(locked_o), 64'd1);

    // Clear, then four consecutive random bad words drop lock.
    drive(1, 0, 32'h0, 1);
    chk("clr_errcnt", 64'(err_cnt_ob), 64'd0);
    chk("clr_frame", 64'(frame_cnt_ob), 64'd0);
    for (int i = 0; i < UNLOCKN; i++) begin
      d = $urandom;
      if (d == model_exp()) d = d ^ 32'h1;
      drive(1, 1, d, 0);
    end
    chk("unlock_state", 64'(state_ob), 64'd1);
    chk("unlock_locked", 64'(locked_o), 64'd0);
    chk("unlock_lost", 64'(lost_lock_o), 64'd1);
    chk("unlock_errcnt", 64'(err_cnt_ob), 64'd4);

    // Randomized traffic, with blocks of heavy corruption.
    for (int blk = 0; blk < 15; blk++) begin
      err_pct = (blk % 3 == 2) ? 75 : 6;
      for (int c = 0; c < 200; c++) begin
        d = ($urandom_range(0, 99) < err_pct) ? 32'($urandom) : model_exp();
        drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), d,
              ($urandom_range(0, 99) == 0));
      end
    end

    // Lock, then saturate the error counter with 3 bad + 1 good words.
    drive(1, 0, 32'h0, 0);
    base = $urandom;
    for (int i = 0; i <= LOCKN; i++) drive(1, 1, base + 32'(i), 0);
    chk("sat_locked", 64'(locked_o), 64'd1);
    drive(1, 0, 32'h0, 1);
    nerr = 0;
    while (nerr < ERRMAX + 6) begin
      for (int j = 0; j < 3; j++) begin
        drive(1, 1, model_exp() + 32'd7, 0);
        nerr++;
      end
      drive(1, 1, model_exp(), 0);
    end
    chk("sat_errcnt", 64'(err_cnt_ob), 64'(ERRMAX));
    chk("sat_still_locked", 64'(locked_o), 64'd1);
    drive(1, 1, model_exp() + 32'd7, 1);
    chk("clr_with_err_err", 64'(err_o), 64'd1);
    chk("clr_with_err_cnt", 64'(err_cnt_ob), 64'd0);

    // Link drop while locked: IDLE next cycle, counters hold, lost set.
    drive(1, 1, model_exp(), 0);
    drive(1, 1, model_exp() + 32'd3, 0);
    drive(1, 1, model_exp(), 0);
    drive(0, 1, model_exp(), 0);
    chk("drop_state", 64'(state_ob), 64'd0);
    chk("drop_locked", 64'(locked_o), 64'd0);
    chk("drop_lost", 64'(lost_lock_o), 64'd1);
    chk("drop_errcnt", 64'(err_cnt_ob), 64'd1);

    // Asynchronous reset in the middle of LOCKING.
    drive(1, 0, 32'h0, 0);
    base = 32'h5000;
    for (int i = 0; i < 5; i++) drive(1, 1, base + 32'(i), 0);
    chk("mid_locking_state", 64'(state_ob), 64'd2);
    #3;
    rst_ir = 1'b1;
    #1;
    check_all_reset("async_rst");
    model_reset();
    @(posedge clk_ik); #1;
    rst_ir = 1'b0;
    drive(1, 0, 32'h0, 0);
    base = 32'h5005;
    for (int i = 0; i < LOCKN; i++) drive(1, 1, base + 32'(i), 0);
    chk("relock_not_yet", 64'(locked_o), 64'd0);
    drive(1, 1, base + 32'(LOCKN), 0);
    chk("relock_done", 64'(locked_o), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gbt_rx_pattern_checker.md
GBT_RX_PATTERN_CHECKER -- requirements
Module: gbt_rx_pattern_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the checked received word.
REQ-002 SHALL have parameter LOCK_COUNT, default 16, consecutive good words required to declare lock.
REQ-003 SHALL have parameter UNLOCK_ERRS, default 4, consecutive bad words that drop lock.
REQ-004 SHALL have parameter ERRCNT_W, default 16, width of the error counter.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port clk_ik  input  1  RX frame clock.
REQ-007 SHALL have port rst_ir  input  1  asynchronous active-high reset.
REQ-008 SHALL have port rx_ready_i  input  1  GBT RX ready; low means link down.
REQ-009 SHALL have port rx_valid_i  input  1  frame-valid strobe (RX clock enable).
REQ-010 SHALL have port rx_data_ib  input  DATA_W  received motor-data word (incrementing counter).
REQ-011 SHALL have port clear_i  input  1  synchronous clear of counters and sticky flag.
REQ-012 SHALL have port locked_o  output  1  pattern lock.
REQ-013 SHALL have port state_ob  output  2  current FSM state code.
REQ-014 SHALL have port err_o  output  1  one-cycle pulse per mismatching word.
REQ-015 SHALL have port err_cnt_ob  output  ERRCNT_W  saturating mismatch count while locked.
REQ-016 SHALL have port frame_cnt_ob  output  32  words checked while locked, wraps.
REQ-017 SHALL have port lost_lock_o  output  1  sticky flag, set on LOCKED->SEARCH.

Function
REQ-018 SHALL sample only on cycles with rx_valid_i=1; all outputs registered, update one clk_ik after the sampling edge.
REQ-019 SHALL compute expected = previous sample + 1 modulo 2^DATA_W; all-ones followed by zero is a match.
REQ-020 SHALL implement states IDLE=0, SEARCH=1, LOCKING=2, LOCKED=3.
REQ-021 IDLE: rx_ready_i=1 -> SEARCH next cycle.
REQ-022 SEARCH: on valid, load expected from rx_data_ib, go LOCKING with good-run count 0.
REQ-023 LOCKING: match increments good-run; reaching LOCK_COUNT -> LOCKED; mismatch -> reload expected from rx_data_ib, good-run 0, stay LOCKING.
REQ-024 LOCKED: match clears bad-run and increments frame_cnt_ob; mismatch pulses err_o, increments err_cnt_ob, increments bad-run, resynchronises expected to rx_data_ib+1.
REQ-025 LOCKED: bad-run reaching UNLOCK_ERRS -> SEARCH and sets lost_lock_o.
REQ-026 rx_ready_i=0 in any state -> IDLE next cycle; counters hold, lost_lock_o set if leaving LOCKED.
REQ-027 locked_o SHALL be 1 exactly when state is LOCKED.
REQ-028 err_cnt_ob SHALL saturate at all-ones, never wrap.
REQ-029 clear_i SHALL zero err_cnt_ob, frame_cnt_ob, lost_lock_o without affecting FSM; clear and simultaneous error -> counter 0, err_o still pulses.
REQ-030 err_o and counters SHALL not change in IDLE, SEARCH or LOCKING.

Reset
REQ-031 rst_ir high SHALL asynchronously force IDLE, locked_o=0, err_o=0, err_cnt_ob=0, frame_cnt_ob=0, lost_lock_o=0, state_ob=0, internal runs and expected to 0.
REQ-032 Reset mid-operation SHALL discard lock; relock requires full SEARCH+LOCKING sequence after release.

Structure
REQ-033 State enum type and default LOCK_COUNT/UNLOCK_ERRS constants SHALL live in the shared project package.
REQ-034 Saturating error counter SHALL be a sub-module sat_counter (width parameter, inc, clr).
REQ-035 Block SHALL sit downstream of the GBT bank, on its received-data output in the RX frame clock domain.

Verification
REQ-036 Counter 0,1,2,... valid every cycle, ready=1 -> locked_o=1 after 1+16 valid words, err_cnt=0.
REQ-037 Locked, inject word 0x1234 instead of 0x0100 once -> err_o one pulse, err_cnt=1, stays locked, next 0x1235 accepted.
REQ-038 Locked, four consecutive random words -> SEARCH, locked_o=0, lost_lock_o=1, err_cnt=4.
REQ-039 Sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 while locked -> no error (wrap).
REQ-040 Force 2^16+5 errors with clear_i low -> err_cnt=0xFFFF; pulse clear_i together with an error -> err_cnt=0, err_o=1.
REQ-041 Drop rx_ready_i while locked, or assert rst_ir mid-LOCKING -> IDLE within one cycle (reset asynchronously), all outputs at reset values.
